// File: rtl/lded_job_scheduler.sv
// Shares one LDED between NREQ requesters: round-robin job admission gated by FIFO space,
// and capture of one LE_Addr per detector cycle. Define LDED_SCHED_STATS_EN for counters.
module lded_job_scheduler #(
    parameter int unsigned ELEMENT_NUM = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned NREQ        = 2,
    parameter int unsigned REQ_W       = 1,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*ELEMENT_NUM-1:0] req_fo,
    output logic [NREQ-1:0]             req_ready,
    output logic                        det_in_valid,
    output logic [ELEMENT_NUM-1:0]      det_fo,
    input  logic                        det_out_vld,
    input  logic [ADDR_W-1:0]           det_le_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [REQ_W-1:0]            out_tag,
    output logic                        out_last,
    output logic                        busy,
    output logic                        err
`ifdef LDED_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]          job_cnt,
    output logic [15:0]                 stall_cnt
`endif
);
    localparam int unsigned CNT_W  = $clog2(ELEMENT_NUM + 1);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CMP_W  = (CNT_W > FCNT_W) ? CNT_W : FCNT_W;
    localparam int unsigned ENT_W  = ADDR_W + REQ_W + 1;

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e                 state_q;
    logic [REQ_W-1:0]       rr_ptr_q;
    logic [REQ_W-1:0]       tag_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       p_q;
    logic                   err_q;

    logic [ELEMENT_NUM-1:0] fo_arr [NREQ];
    logic                   cand_found;
    logic [REQ_W-1:0]       cand;
    logic [REQ_W-1:0]       scan_idx;
    logic [ELEMENT_NUM-1:0] cand_fo;
    logic [CNT_W-1:0]       cand_pop;
    logic [CMP_W-1:0]       free_ent;
    logic                   fits;
    logic                   grant;
    logic                   push;
    logic                   push_last;
    logic                   pop;

    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_nxt;
    logic [FCNT_W-1:0]      fcnt_q;
    logic [FCNT_W-1:0]      fcnt_d;
    logic [FCNT_W-1:0]      remain;
    logic [ENT_W-1:0]       push_ent;
    logic [ENT_W-1:0]       head_q;
    logic [ENT_W-1:0]       head_d;
    logic                   head_vld_d;
    logic                   out_valid_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_fo
        assign fo_arr[g] = req_fo[g*ELEMENT_NUM +: ELEMENT_NUM];
    end

    // Scan starts one past the last grant so every requester gets its turn.
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        scan_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = REQ_W'((32'(rr_ptr_q) + k) % NREQ);
            if (!cand_found && req_valid[scan_idx]) begin
                cand_found = 1'b1;
                cand       = scan_idx;
            end
        end
    end

    assign cand_fo = fo_arr[cand];

    always_comb begin
        cand_pop = '0;
        for (int unsigned b = 0; b < ELEMENT_NUM; b++) begin
            cand_pop = cand_pop + CNT_W'(cand_fo[b]);
        end
    end

    // A blocked candidate is never skipped; it waits until its whole job fits.
    assign free_ent     = CMP_W'(FIFO_DEPTH) - CMP_W'(fcnt_q);
    assign fits         = free_ent >= CMP_W'(cand_pop);
    assign grant        = rst_n && (state_q == StIdle) && cand_found && fits;

    assign req_ready    = grant ? (NREQ'(1) << cand) : '0;
    assign det_in_valid = grant;
    assign det_fo       = grant ? cand_fo : '0;
    assign push         = (state_q == StDrain) && det_out_vld;
    assign push_last    = (cnt_q == p_q - 1'b1);
    assign busy         = (state_q == StDrain);
    assign err          = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant) begin
                        rr_ptr_q <= cand;
                        tag_q    <= cand;
                        p_q      <= cand_pop;
                        cnt_q    <= '0;
                        if (cand_pop != '0) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (det_out_vld) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (push_last) state_q <= StIdle;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output FIFO; head_q mirrors the oldest entry so out_* hold their value when empty.
    assign pop        = out_valid_q && out_ready;
    assign push_ent   = {det_le_addr, tag_q, push_last};
    assign rd_ptr_nxt = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    assign remain     = fcnt_q - FCNT_W'(pop);

    always_comb begin
        fcnt_d = remain + FCNT_W'(push);
        if (remain == '0) begin
            head_d     = push_ent;
            head_vld_d = push;
        end else begin
            head_d     = mem_q[rd_ptr_nxt];
            head_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            rd_ptr_q    <= rd_ptr_nxt;
            fcnt_q      <= fcnt_d;
            out_valid_q <= head_vld_d;
            if (head_vld_d) head_q <= head_d;
        end
    end

    assign out_valid                     = out_valid_q;
    assign {out_addr, out_tag, out_last} = head_q;

`ifdef LDED_SCHED_STATS_EN
    logic [15:0] job_q [NREQ];
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) job_q[i] <= '0;
            stall_q <= '0;
        end else begin
            if (grant) job_q[cand] <= job_q[cand] + 16'd1;
            if ((state_q == StIdle) && cand_found && !fits) stall_q <= stall_q + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_job
        assign job_cnt[g*16 +: 16] = job_q[g];
    end
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_lded_job_scheduler.sv
// Bench for lded_job_scheduler: behavioural detector, job-level reference model feeding a
// scoreboard queue, and an independent monitor that checks every popped output entry.
module tb_lded_job_scheduler;
    localparam int unsigned EN    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned NR    = 2;
    localparam int unsigned RW    = 1;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] tag;
        logic          last;
    } ent_t;

    logic           clk;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR*EN-1:0] req_fo;
    logic [NR-1:0]  req_ready;
    logic           det_in_valid;
    logic [EN-1:0]  det_fo;
    logic           det_out_vld;
    logic [AW-1:0]  det_le_addr;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  out_addr;
    logic [RW-1:0]  out_tag;
    logic           out_last;
    logic           busy;
    logic           err;

    int n_checks = 0;
    int n_errors = 0;

    lded_job_scheduler #(
        .ELEMENT_NUM(EN), .ADDR_W(AW), .NREQ(NR), .REQ_W(RW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_fo(req_fo),
        .req_ready(req_ready), .det_in_valid(det_in_valid), .det_fo(det_fo),
        .det_out_vld(det_out_vld), .det_le_addr(det_le_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_tag(out_tag), .out_last(out_last),
        .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Detector: after a load it emits the set bits lowest-first, one per cycle.
    logic [EN-1:0] det_bits;
    logic          det_kill;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) det_bits <= '0;
        else if (det_in_valid) det_bits <= det_fo;
        else if (det_out_vld) det_bits <= det_bits & (det_bits - 1'b1);
    end

    always_comb begin
        det_le_addr = '0;
        for (int b = EN - 1; b >= 0; b--) if (det_bits[b]) det_le_addr = AW'(b);
        det_out_vld = (det_bits != '0) && !det_kill;
    end

    // Reference model: jobs waiting to drain, entries expected in order, FIFO occupancy.
    ent_t          sb[$];
    ent_t          pend[$];
    int            occ_m;
    int            rr_m;
    bit            err_m;
    logic [NR-1:0] hs;
    logic [NR-1:0] got_hs;

    always @(negedge clk) begin : model
        bit            found;
        bit            g;
        bit            pushed;
        bit            popped;
        int            cand;
        int            idx;
        logic [EN-1:0] fo;
        ent_t          e;
        hs = req_valid & req_ready;
        if (!rst_n) begin
            occ_m = 0;
            rr_m  = 0;
            err_m = 0;
            pend.delete();
            sb.delete();
            check("reset_outputs", {req_ready, det_in_valid, det_fo, out_valid, out_addr,
                                    out_tag, out_last, busy, err}, 0);
        end else begin
            check("out_valid", out_valid, occ_m != 0);
            check("busy", busy, pend.size() != 0);
            check("err", err, err_m);
            found = 0;
            g     = 0;
            cand  = 0;
            fo    = '0;
            if (pend.size() == 0) begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (rr_m + k) % NR;
                    if (!found && req_valid[idx]) begin
                        found = 1;
                        cand  = idx;
                    end
                end
            end
            if (found) begin
                fo = req_fo[cand*EN +: EN];
                g  = (DEPTH - occ_m) >= $countones(fo);
            end
            check("req_ready", req_ready, g ? (1 << cand) : 0);
            check("det_in_valid", det_in_valid, g);
            check("det_fo", det_fo, g ? fo : 0);
            popped = (occ_m != 0) && out_ready;
            pushed = 0;
            if (pend.size() != 0) begin
                if (det_kill) begin
                    err_m = 1;
                    pend.delete();
                end else begin
                    sb.push_back(pend.pop_front());
                    pushed = 1;
                end
            end
            occ_m = occ_m + int'(pushed) - int'(popped);
            if (g) begin
                rr_m = cand;
                for (int b = 0; b < EN; b++) begin
                    if (fo[b]) begin
                        e.addr = AW'(b);
                        e.tag  = RW'(cand);
                        e.last = 1'b0;
                        pend.push_back(e);
                    end
                end
                if (pend.size() != 0) pend[pend.size()-1].last = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        ent_t exp_e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("pop_expected", out_valid, 0);
            end else begin
                exp_e = sb.pop_front();
                check("out_entry", {out_addr, out_tag, out_last}, exp_e);
            end
        end
    end

    function automatic logic [EN-1:0] rand_fo();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return EN'(1) << $urandom_range(0, EN - 1);
            2:       return EN'($urandom);
            default: return EN'($urandom & $urandom);
        endcase
    endfunction

    task automatic cycle(input bit refill);
        @(posedge clk);
        #1;
        got_hs = hs;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                if (refill) req_fo[i*EN +: EN] = rand_fo();
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_hs(input int i, input int budget, input string name);
        bit got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            cycle(0);
            got = got_hs[i];
        end
        check(name, got, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_fo    = {NR{16'hFFFF}};
        out_ready = 1'b0;
        det_kill  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Single job 0x0025: addresses 0, 2, 5 with tag 0.
        out_ready         = 1'b1;
        req_fo[0 +: EN]   = 16'h0025;
        req_valid         = 2'b01;
        wait_hs(0, 5, "grant_0025");
        repeat (8) cycle(0);

        // Both requesters continuously valid: grants alternate.
        req_fo    = {16'h0103, 16'h8001};
        req_valid = '1;
        repeat (30) cycle(1);
        req_valid = '0;
        repeat (20) cycle(0);

        // Two full jobs with a stalled consumer: second waits for 16 free entries.
        out_ready = 1'b0;
        req_fo    = {NR{16'hFFFF}};
        req_valid = '1;
        repeat (25) cycle(0);
        check("second_full_blocked", $countones(req_valid), 1);
        out_ready = 1'b1;
        repeat (45) cycle(0);
        check("both_full_taken", req_valid, 0);

        // Empty bitmap is accepted and dropped; the other job follows next cycle.
        req_fo    = {16'h0003, 16'h0000};
        req_valid = '1;
        repeat (10) cycle(0);
        check("zero_job_taken", req_valid, 0);

        // Detector drains early on the second cycle of a 3-bit job.
        req_fo[0 +: EN] = 16'h0007;
        req_valid       = 2'b01;
        wait_hs(0, 10, "grant_kill_job");
        cycle(0);
        det_kill = 1'b1;
        cycle(0);
        det_kill = 1'b0;
        repeat (5) cycle(0);
        check("err_sticky", err, 1);

        // Reset in the middle of a drain with five entries held.
        out_ready        = 1'b0;
        req_fo[0 +: EN]  = 16'h001F;
        req_valid        = 2'b01;
        wait_hs(0, 10, "grant_five");
        repeat (6) cycle(0);
        req_fo[EN +: EN] = 16'h00FF;
        req_valid        = 2'b10;
        wait_hs(1, 10, "grant_mid_reset");
        cycle(0);
        cycle(0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {req_ready, det_in_valid, det_fo, out_valid, out_addr,
                                      out_tag, out_last, busy, err}, 0);
        cycle(0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) cycle(0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_fo[i*EN +: EN] = rand_fo();
                    req_valid[i]       = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(0);
        end
        req_valid = '0;
        out_ready = 1'b1;
        repeat (40) cycle(0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
